// File: rtl/iram_load_ctrl_pkg.sv
// Shared constants and state encodings for the IRAM program-load controller.
package iram_load_ctrl_pkg;

   localparam int IRAM_DEPTH = 128;
   localparam int IRAM_AW    = 7;
   localparam int INSTR_W    = 16;

   localparam logic [INSTR_W-1:0] NOP = 16'h0000;

   typedef enum logic [2:0] {
      LDS_IDLE    = 3'd0,
      LDS_FILL    = 3'd1,
      LDS_RECV_HI = 3'd2,
      LDS_RECV_LO = 3'd3,
      LDS_WRITE   = 3'd4,
      LDS_DRAIN   = 3'd5
   } ld_state_e;

endpackage

// File: rtl/iram_load_ctrl_if.sv
// Host load stream, CPU fetch path and IRAM port bundle for iram_load_ctrl.
interface iram_load_ctrl_if
   import iram_load_ctrl_pkg::*;
#(
   parameter int AW = IRAM_AW,
   parameter int DW = INSTR_W
);
   // Load stream: a byte moves on a rising CLK edge where LD_VALID and LD_READY
   // are both high; LD_DATA/LD_LAST must stay stable while LD_VALID waits for LD_READY.
   logic          LD_START;
   logic          LD_VALID;
   logic [7:0]    LD_DATA;
   logic          LD_LAST;
   logic          LD_READY;

   logic [7:0]    CPU_ADDR;
   logic [DW-1:0] CPU_Q;
   logic          CPU_STALL;

   logic [AW-1:0] MEM_RADDR;
   logic [DW-1:0] MEM_RDATA;
   logic          MEM_WE;
   logic [AW-1:0] MEM_WADDR;
   logic [DW-1:0] MEM_WDATA;

   logic          BUSY;
   logic          DONE;
   logic          ERR;
   logic [AW:0]   WORD_CNT;
   ld_state_e     STATE;

   modport slave (
      input  LD_START, LD_VALID, LD_DATA, LD_LAST, CPU_ADDR, MEM_RDATA,
      output LD_READY, CPU_Q, CPU_STALL, MEM_RADDR, MEM_WE, MEM_WADDR, MEM_WDATA,
             BUSY, DONE, ERR, WORD_CNT, STATE
   );

   modport master (
      output LD_START, LD_VALID, LD_DATA, LD_LAST, CPU_ADDR, MEM_RDATA,
      input  LD_READY, CPU_Q, CPU_STALL, MEM_RADDR, MEM_WE, MEM_WADDR, MEM_WDATA,
             BUSY, DONE, ERR, WORD_CNT, STATE
   );

endinterface

// File: rtl/iram_load_ctrl_byte_packer.sv
// Assembles two stream bytes (high first) into one instruction word,
// zero-padding the low byte when the stream ends on a high byte.
module iram_byte_packer
   import iram_load_ctrl_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET,
   input  logic               hi_en,
   input  logic               lo_en,
   input  logic [7:0]         byte_in,
   input  logic               last_in,
   output logic [INSTR_W-1:0] word,
   output logic               word_last
);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         word      <= '0;
         word_last <= 1'b0;
      end else if (hi_en) begin
         word[15:8] <= byte_in;
         word_last  <= last_in;
         if (last_in) begin
            word[7:0] <= 8'h00;
         end
      end else if (lo_en) begin
         word[7:0] <= byte_in;
         word_last <= last_in;
      end
   end

endmodule

// File: rtl/iram_load_ctrl.sv
// Program-load controller: optional zero-fill, byte-stream load into IRAM,
// and fetch-path arbitration that stalls the CPU with NOPs while loading.
module iram_load_ctrl
   import iram_load_ctrl_pkg::*;
#(
   parameter int DEPTH   = IRAM_DEPTH,
   parameter int AW      = IRAM_AW,
   parameter int DW      = INSTR_W,
   parameter bit FILL_EN = 1'b1
) (
   input  logic            CLK,
   input  logic            RESET,
   iram_load_ctrl_if.slave bus
);

   localparam int            PW       = AW + 1;
   localparam logic [PW-1:0] FILL_END = PW'(DEPTH - 1);
   localparam logic [PW-1:0] FULL     = PW'(DEPTH);
   localparam logic [PW-1:0] ONE      = PW'(1);

   ld_state_e     state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          ld_ready, mem_we, full, stall;
   logic [DW-1:0] word;
   logic          word_last;
   logic          unused_addr_lsb;

   assign full  = (ptr_q == FULL);
   assign stall = (state_q != LDS_IDLE);

   iram_byte_packer u_packer (
      .CLK       (CLK),
      .RESET     (RESET),
      .hi_en     ((state_q == LDS_RECV_HI) && bus.LD_VALID),
      .lo_en     ((state_q == LDS_RECV_LO) && bus.LD_VALID),
      .byte_in   (bus.LD_DATA),
      .last_in   (bus.LD_LAST),
      .word      (word),
      .word_last (word_last)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= LDS_IDLE;
         ptr_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      done_d   = done_q;
      err_d    = err_q;
      ld_ready = 1'b0;
      mem_we   = 1'b0;
      unique case (state_q)
         LDS_IDLE: begin
            if (bus.LD_START) begin
               state_d = FILL_EN ? LDS_FILL : LDS_RECV_HI;
               ptr_d   = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         LDS_FILL: begin
            mem_we = 1'b1;
            if (ptr_q == FILL_END) begin
               state_d = LDS_RECV_HI;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + ONE;
            end
         end
         LDS_RECV_HI: begin
            ld_ready = 1'b1;
            if (bus.LD_VALID) begin
               if (bus.LD_LAST) begin
                  // Odd-length stream: the padded word is still written unless IRAM is full.
                  err_d = 1'b1;
                  if (full) begin
                     state_d = LDS_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = LDS_WRITE;
                  end
               end else begin
                  state_d = LDS_RECV_LO;
               end
            end
         end
         LDS_RECV_LO: begin
            ld_ready = 1'b1;
            if (bus.LD_VALID) begin
               if (full) begin
                  err_d = 1'b1;
                  if (bus.LD_LAST) begin
                     state_d = LDS_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = LDS_DRAIN;
                  end
               end else begin
                  state_d = LDS_WRITE;
               end
            end
         end
         LDS_WRITE: begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + ONE;
            if (word_last) begin
               state_d = LDS_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = LDS_RECV_HI;
            end
         end
         LDS_DRAIN: begin
            ld_ready = 1'b1;
            if (bus.LD_VALID && bus.LD_LAST) begin
               state_d = LDS_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = LDS_IDLE;
      endcase
   end

   // The fetch address LSB selects a byte within a word and has no meaning here.
   assign unused_addr_lsb = bus.CPU_ADDR[0];

   assign bus.LD_READY  = ld_ready;
   assign bus.MEM_WE    = mem_we;
   assign bus.MEM_WADDR = ptr_q[AW-1:0];
   assign bus.MEM_WDATA = (state_q == LDS_WRITE) ? word : '0;
   assign bus.MEM_RADDR = bus.CPU_ADDR[7:1];
   assign bus.CPU_STALL = stall;
   assign bus.CPU_Q     = stall ? DW'(NOP) : bus.MEM_RDATA;
   assign bus.BUSY      = stall;
   assign bus.DONE      = done_q;
   assign bus.ERR       = err_q;
   assign bus.WORD_CNT  = (state_q == LDS_FILL) ? '0 : ptr_q;
   assign bus.STATE     = state_q;

endmodule

// File: tb/tb_iram_load_ctrl.sv
// Directed bench for iram_load_ctrl: a fill-enabled and a fill-disabled instance
// share the stream inputs; IRAM writes are checked against an expected queue.
module tb_iram_load_ctrl;
   import iram_load_ctrl_pkg::*;

   localparam int AW = IRAM_AW;
   localparam int DW = INSTR_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          ld_start_f  = 1'b0;
   logic          ld_start_nf = 1'b0;
   logic          ld_valid    = 1'b0;
   logic          ld_last     = 1'b0;
   logic [7:0]    ld_data     = 8'h00;
   logic [7:0]    cpu_addr    = 8'h00;
   logic [DW-1:0] mem_rdata   = '0;
   logic          sel_nf      = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   logic [AW+DW-1:0] exp_q[$];
   logic [7:0]       stream[$];
   logic [7:0]       bh, bl;

   iram_load_ctrl_if if_f ();
   iram_load_ctrl_if if_nf ();

   assign if_f.LD_START   = ld_start_f;
   assign if_f.LD_VALID   = ld_valid;
   assign if_f.LD_DATA    = ld_data;
   assign if_f.LD_LAST    = ld_last;
   assign if_f.CPU_ADDR   = cpu_addr;
   assign if_f.MEM_RDATA  = mem_rdata;
   assign if_nf.LD_START  = ld_start_nf;
   assign if_nf.LD_VALID  = ld_valid;
   assign if_nf.LD_DATA   = ld_data;
   assign if_nf.LD_LAST   = ld_last;
   assign if_nf.CPU_ADDR  = cpu_addr;
   assign if_nf.MEM_RDATA = mem_rdata;

   iram_load_ctrl #(.FILL_EN(1'b1)) u_fill (
      .CLK   (clk),
      .RESET (rst),
      .bus   (if_f)
   );

   iram_load_ctrl #(.FILL_EN(1'b0)) u_nofill (
      .CLK   (clk),
      .RESET (rst),
      .bus   (if_nf)
   );

   // Signals of the instance currently under test, and the other one.
   logic          s_we, s_ready, s_stall, s_busy, s_done, s_err, o_we;
   logic [AW-1:0] s_waddr, s_raddr;
   logic [DW-1:0] s_wdata, s_q;
   logic [AW:0]   s_cnt;
   ld_state_e     s_state;

   assign s_we    = sel_nf ? if_nf.MEM_WE    : if_f.MEM_WE;
   assign s_ready = sel_nf ? if_nf.LD_READY  : if_f.LD_READY;
   assign s_stall = sel_nf ? if_nf.CPU_STALL : if_f.CPU_STALL;
   assign s_busy  = sel_nf ? if_nf.BUSY      : if_f.BUSY;
   assign s_done  = sel_nf ? if_nf.DONE      : if_f.DONE;
   assign s_err   = sel_nf ? if_nf.ERR       : if_f.ERR;
   assign s_waddr = sel_nf ? if_nf.MEM_WADDR : if_f.MEM_WADDR;
   assign s_raddr = sel_nf ? if_nf.MEM_RADDR : if_f.MEM_RADDR;
   assign s_wdata = sel_nf ? if_nf.MEM_WDATA : if_f.MEM_WDATA;
   assign s_q     = sel_nf ? if_nf.CPU_Q     : if_f.CPU_Q;
   assign s_cnt   = sel_nf ? if_nf.WORD_CNT  : if_f.WORD_CNT;
   assign s_state = sel_nf ? if_nf.STATE     : if_f.STATE;
   assign o_we    = sel_nf ? if_f.MEM_WE     : if_nf.MEM_WE;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every IRAM write must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (s_we) begin
            check("we_ready_low", 32'(s_ready), 32'd0);
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               check("write", 32'({s_waddr, s_wdata}), 32'(exp_q.pop_front()));
            end
         end
         if (o_we) check("idle_dut_we", 32'(o_we), 32'd0);
      end
   end

   task automatic start(input logic nf);
      sel_nf = nf;
      if (nf) ld_start_nf = 1'b1;
      else    ld_start_f  = 1'b1;
      @(posedge clk); #1;
      ld_start_f  = 1'b0;
      ld_start_nf = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
      bit got;
      ld_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
      ld_valid = 1'b1;
      ld_data  = b;
      ld_last  = last;
      got      = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         @(negedge clk);
         got = s_ready;
         @(posedge clk); #1;
      end
      if (!got) check("send_timeout", 32'd0, 32'd1);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int c = 0; c < 2000 && !idle; c++) begin
         @(negedge clk);
         idle = !s_busy;
      end
      if (!idle) check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic push_fill();
      for (int i = 0; i < IRAM_DEPTH; i++) exp_q.push_back({AW'(i), 16'h0000});
   endtask

   initial begin
      // Reset and unstalled fetch pass-through
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      cpu_addr  = 8'h06;
      mem_rdata = 16'hA5C3;
      @(negedge clk);
      check("t1_cpu_q", 32'(s_q), 32'hA5C3);
      check("t1_stall", 32'(s_stall), 32'd0);
      check("t1_busy", 32'(s_busy), 32'd0);
      check("t1_done", 32'(s_done), 32'd0);
      check("t1_err", 32'(s_err), 32'd0);
      check("t1_ready", 32'(s_ready), 32'd0);
      check("t1_cnt", 32'(s_cnt), 32'd0);
      check("t1_waddr", 32'({s_waddr, s_wdata}), 32'd0);
      check("t1_raddr", 32'(s_raddr), 32'd3);
      cpu_addr = 8'h07;
      @(negedge clk);
      check("t1_raddr_odd", 32'(s_raddr), 32'd3);
      @(posedge clk); #1;

      // Zero-fill then a two-word load
      push_fill();
      exp_q.push_back({7'd0, 16'h1234});
      exp_q.push_back({7'd1, 16'h5678});
      start(1'b0);
      @(negedge clk);
      check("t2_busy", 32'(s_busy), 32'd1);
      check("t2_stall", 32'(s_stall), 32'd1);
      check("t2_nop", 32'(s_q), 32'h0000);
      @(posedge clk); #1;
      send_byte(8'h12, 1'b0, 0);
      send_byte(8'h34, 1'b0, 0);
      send_byte(8'h56, 1'b0, 0);
      send_byte(8'h78, 1'b1, 0);
      @(negedge clk);
      check("t2_last_we", 32'(s_we), 32'd1);
      check("t2_last_stall", 32'(s_stall), 32'd1);
      @(negedge clk);
      check("t2_stall_low", 32'(s_stall), 32'd0);
      check("t2_cnt", 32'(s_cnt), 32'd2);
      check("t2_done", 32'(s_done), 32'd1);
      check("t2_err", 32'(s_err), 32'd0);
      check("t2_q_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;

      // Odd-length stream pads the final low byte
      push_fill();
      exp_q.push_back({7'd0, 16'hABCD});
      exp_q.push_back({7'd1, 16'hEF00});
      start(1'b0);
      @(negedge clk);
      check("t3_done_clr", 32'(s_done), 32'd0);
      check("t3_cnt_clr", 32'(s_cnt), 32'd0);
      @(posedge clk); #1;
      send_byte(8'hAB, 1'b0, 0);
      send_byte(8'hCD, 1'b0, 0);
      send_byte(8'hEF, 1'b1, 0);
      wait_idle();
      check("t3_err", 32'(s_err), 32'd1);
      check("t3_done", 32'(s_done), 32'd1);
      check("t3_cnt", 32'(s_cnt), 32'd2);
      check("t3_q_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;

      // Overflow: 258 bytes into the fill-less instance, last on the 129th word
      stream.delete();
      for (int i = 0; i < 129; i++) begin
         bh = 8'($urandom_range(0, 255));
         bl = 8'($urandom_range(0, 255));
         stream.push_back(bh);
         stream.push_back(bl);
         if (i < IRAM_DEPTH) exp_q.push_back({AW'(i), bh, bl});
      end
      start(1'b1);
      for (int i = 0; i < stream.size(); i++) send_byte(stream[i], i == stream.size() - 1, 0);
      wait_idle();
      check("t4_err", 32'(s_err), 32'd1);
      check("t4_cnt", 32'(s_cnt), 32'd128);
      check("t4_done", 32'(s_done), 32'd1);
      check("t4_q_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;

      // Overflow without last: excess bytes are drained until LD_LAST
      for (int i = 0; i < IRAM_DEPTH; i++) exp_q.push_back({AW'(i), 8'(i), 8'(~i)});
      start(1'b1);
      for (int i = 0; i < IRAM_DEPTH; i++) begin
         send_byte(8'(i), 1'b0, 0);
         send_byte(8'(~i), 1'b0, 0);
      end
      send_byte(8'h11, 1'b0, 0);
      send_byte(8'h22, 1'b0, 0);
      @(negedge clk);
      check("t4b_drain", 32'(s_state), 32'(LDS_DRAIN));
      check("t4b_drain_busy", 32'(s_busy), 32'd1);
      @(posedge clk); #1;
      send_byte(8'h33, 1'b0, 1);
      send_byte(8'h44, 1'b1, 0);
      wait_idle();
      check("t4b_err", 32'(s_err), 32'd1);
      check("t4b_cnt", 32'(s_cnt), 32'd128);
      check("t4b_done", 32'(s_done), 32'd1);
      check("t4b_q_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;

      // Random LD_VALID gaps give the same words as the gapless run
      exp_q.push_back({7'd0, 16'h1234});
      exp_q.push_back({7'd1, 16'h5678});
      start(1'b1);
      send_byte(8'h12, 1'b0, $urandom_range(0, 3));
      send_byte(8'h34, 1'b0, $urandom_range(1, 3));
      send_byte(8'h56, 1'b0, $urandom_range(0, 3));
      send_byte(8'h78, 1'b1, $urandom_range(1, 3));
      wait_idle();
      check("t5_cnt", 32'(s_cnt), 32'd2);
      check("t5_err", 32'(s_err), 32'd0);
      check("t5_done", 32'(s_done), 32'd1);
      check("t5_q_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;

      // Reset in RECV_LO after one word, with LD_START held alongside it
      exp_q.push_back({7'd0, 16'h1122});
      start(1'b1);
      send_byte(8'h11, 1'b0, 0);
      send_byte(8'h22, 1'b0, 0);
      send_byte(8'h33, 1'b0, 0);
      @(negedge clk);
      check("t6_in_lo", 32'(s_state), 32'(LDS_RECV_LO));
      @(posedge clk); #1;
      rst         = 1'b1;
      ld_start_nf = 1'b1;
      @(posedge clk); #1;
      rst         = 1'b0;
      ld_start_nf = 1'b0;
      @(negedge clk);
      check("t6_state", 32'(s_state), 32'(LDS_IDLE));
      check("t6_busy", 32'(s_busy), 32'd0);
      check("t6_stall", 32'(s_stall), 32'd0);
      check("t6_ready", 32'(s_ready), 32'd0);
      check("t6_done", 32'(s_done), 32'd0);
      check("t6_err", 32'(s_err), 32'd0);
      check("t6_cnt", 32'(s_cnt), 32'd0);
      check("t6_wbus", 32'({s_we, s_waddr, s_wdata}), 32'd0);
      check("t6_q_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
      exp_q.push_back({7'd0, 16'h9ABC});
      start(1'b1);
      send_byte(8'h9A, 1'b0, 0);
      send_byte(8'hBC, 1'b1, 0);
      wait_idle();
      check("t6_reload_cnt", 32'(s_cnt), 32'd1);
      check("t6_reload_done", 32'(s_done), 32'd1);
      check("t6_reload_err", 32'(s_err), 32'd0);
      check("t6_reload_q_empty", 32'(exp_q.size()), 32'd0);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
